// File: rtl/acorn_init_seq.sv
// ACORN-128 initialization sequencer.
// Runs the 1792-step key/IV load in place on the 293-bit state. It applies
// BITS_PER_CYCLE steps per clock and derives each message bit from the step index.
`timescale 1ns/1ps

// One combinational ACORN-128 state-update step (the StateUpdate128 function).
// clk/rst exist only so integrators can tie them off; the function is pure logic.
module state_update128 (
  input  logic         clk,
  input  logic         rst,
  input  logic [292:0] i_state,
  input  logic         i_m,
  input  logic         i_ca,
  input  logic         i_cb,
  output logic [292:0] o_state,
  output logic         o_ks
);

  logic         w_unused;
  logic [292:0] w_s;
  logic         w_ks;
  logic         w_f;

  assign w_unused = &{1'b0, clk, rst};

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  // LFSR tap mixing, keystream and feedback bit, then a one-position shift.
  always_comb begin
    // NOTE: blocking assignments here are deliberate: each tap update must see
    // the ones applied above it, exactly like the sequential reference code.
    w_s = i_state;
    w_s[289] = w_s[289] ^ w_s[235] ^ w_s[230];
    w_s[230] = w_s[230] ^ w_s[196] ^ w_s[193];
    w_s[193] = w_s[193] ^ w_s[160] ^ w_s[154];
    w_s[154] = w_s[154] ^ w_s[111] ^ w_s[107];
    w_s[107] = w_s[107] ^ w_s[66]  ^ w_s[61];
    w_s[61]  = w_s[61]  ^ w_s[23]  ^ w_s[0];
    w_ks = w_s[12] ^ w_s[154] ^ maj(w_s[235], w_s[61], w_s[193])
         ^ ch(w_s[230], w_s[111], w_s[66]);
    w_f  = w_s[0] ^ ~w_s[107] ^ maj(w_s[244], w_s[23], w_s[160])
         ^ (i_ca & w_s[196]) ^ (i_cb & w_ks) ^ i_m;
    o_state = {w_f, w_s[292:1]};
    o_ks    = w_ks;
  end

endmodule

module acorn_init_seq #(
  parameter int BITS_PER_CYCLE = 1,
  parameter int INIT_STEPS     = 1792
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic           abort_i,
  input  logic [127:0]   key_in,
  input  logic [127:0]   iv_in,
  output logic           busy_o,
  output logic           done_o,
  output logic [292:0]   state_out,
  output logic [10:0]    step_o
);

  // Only a small set of unroll factors is supported; anything else stops elaboration.
  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 ||
        BITS_PER_CYCLE == 8 || BITS_PER_CYCLE == 16)) begin : g_bad_bpc
    $error("acorn_init_seq: BITS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end
  if ((INIT_STEPS % BITS_PER_CYCLE) != 0 || INIT_STEPS < 257 ||
      INIT_STEPS > 2047) begin : g_bad_steps
    $error("acorn_init_seq: INIT_STEPS must be a multiple of BITS_PER_CYCLE in 257..2047");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [10:0] LP_STEP_INC  = 11'(BITS_PER_CYCLE);
  localparam logic [10:0] LP_STEP_LAST = 11'(INIT_STEPS - BITS_PER_CYCLE);

  state_e               r_fsm;
  state_e               w_fsm_nxt;
  logic [127:0]         r_key;
  logic [127:0]         r_iv;
  logic [292:0]         r_acorn;
  logic [10:0]          r_step;

  logic                 w_accept;
  logic                 w_abort;
  logic                 w_advance;
  logic                 w_last;
  logic [BITS_PER_CYCLE-1:0] w_msg;
  logic [BITS_PER_CYCLE-1:0] w_ks_unused;
  logic [292:0]         w_chain [0:BITS_PER_CYCLE];

  // Message bit for step j: key, then IV, then key[0]^1 once, then key repeating.
  function automatic logic msg_bit(input logic [10:0] idx, input logic [127:0] key,
                                   input logic [127:0] iv);
    logic b;
    if (idx[10:7] == 4'd0)       b = key[idx[6:0]];
    else if (idx[10:7] == 4'd1)  b = iv[idx[6:0]];
    else if (idx == 11'd256)     b = ~key[0];
    else                         b = key[idx[6:0]];
    return b;
  endfunction

  assign w_accept  = ((r_fsm == ST_IDLE) || (r_fsm == ST_DONE)) && start_i;
  assign w_abort   = (r_fsm == ST_RUN) && abort_i;
  assign w_advance = (r_fsm == ST_RUN) && !abort_i;
  assign w_last    = (r_step == LP_STEP_LAST);

  assign w_chain[0] = r_acorn;

  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    logic [10:0] w_idx;
    assign w_idx    = r_step + 11'(k);
    assign w_msg[k] = msg_bit(w_idx, r_key, r_iv);

    state_update128 u_su (
      .clk     (clk),
      .rst     (~rst_n),
      .i_state (w_chain[k]),
      .i_m     (w_msg[k]),
      .i_ca    (1'b1),
      .i_cb    (1'b1),
      .o_state (w_chain[k+1]),
      .o_ks    (w_ks_unused[k])
    );
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) r_fsm <= ST_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  // Next-state decode; abort outranks completion while running.
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      ST_IDLE: if (start_i) w_fsm_nxt = ST_RUN;
      ST_RUN: begin
        if (abort_i)     w_fsm_nxt = ST_IDLE;
        else if (w_last) w_fsm_nxt = ST_DONE;
      end
      ST_DONE: if (start_i) w_fsm_nxt = ST_RUN;
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  // Key/IV capture on an accepted start; ignored while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key <= '0;
      r_iv  <= '0;
    end else if (w_accept) begin
      r_key <= key_in;
      r_iv  <= iv_in;
    end
  end

  // ACORN state: cleared on start/abort, advanced by the step chain in RUN, frozen otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_acorn <= '0;
    else if (w_accept || w_abort) r_acorn <= '0;
    else if (w_advance)           r_acorn <= w_chain[BITS_PER_CYCLE];
  end

  // Step index: counts groups, parks on the last group so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_step <= '0;
    else if (w_accept || w_abort)    r_step <= '0;
    else if (w_advance && !w_last)   r_step <= r_step + LP_STEP_INC;
  end

  assign busy_o    = (r_fsm == ST_RUN);
  assign done_o    = (r_fsm == ST_DONE);
  assign state_out = r_acorn;
  assign step_o    = r_step;

endmodule

// File: tb/tb_acorn_init_seq.sv
// Self-checking bench for acorn_init_seq: a 1-bit/cycle and a 16-bit/cycle
// instance share stimulus and are checked against an array-based ACORN model.
`timescale 1ns/1ps

module tb_acorn_init_seq;

  localparam int STEPS = 1792;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] iv_in = '0;

  logic         busy_a, done_a, busy_b, done_b;
  logic [292:0] state_a, state_b;
  logic [10:0]  step_a, step_b;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  acorn_init_seq #(.BITS_PER_CYCLE(1), .INIT_STEPS(STEPS)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .key_in(key_in), .iv_in(iv_in), .busy_o(busy_a), .done_o(done_a),
    .state_out(state_a), .step_o(step_a)
  );

  acorn_init_seq #(.BITS_PER_CYCLE(16), .INIT_STEPS(STEPS)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .key_in(key_in), .iv_in(iv_in), .busy_o(busy_b), .done_o(done_b),
    .state_out(state_b), .step_o(step_b)
  );

  task automatic check(input string tag, input logic [292:0] got, input logic [292:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Message schedule straight from the rules: key, IV, ~key[0], key repeating.
  function automatic bit model_msg(input logic [127:0] k, input logic [127:0] v, input int j);
    if (j < 128)       return k[j];
    else if (j < 256)  return v[j - 128];
    else if (j == 256) return ~k[0];
    else               return k[j % 128];
  endfunction

  function automatic bit maj(input bit x, input bit y, input bit z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic bit ch(input bit x, input bit y, input bit z);
    return (x & y) ^ (~x & z);
  endfunction

  // Reference initialization on a bit array, one step at a time.
  function automatic logic [292:0] model_init(input logic [127:0] k, input logic [127:0] v);
    bit s [0:292];
    bit ks, f;
    logic [292:0] r;
    for (int i = 0; i < 293; i++) s[i] = 1'b0;
    for (int j = 0; j < STEPS; j++) begin
      s[289] ^= s[235] ^ s[230];
      s[230] ^= s[196] ^ s[193];
      s[193] ^= s[160] ^ s[154];
      s[154] ^= s[111] ^ s[107];
      s[107] ^= s[66] ^ s[61];
      s[61]  ^= s[23] ^ s[0];
      ks = s[12] ^ s[154] ^ maj(s[235], s[61], s[193]) ^ ch(s[230], s[111], s[66]);
      f  = s[0] ^ ~s[107] ^ maj(s[244], s[23], s[160]) ^ s[196] ^ ks ^ model_msg(k, v, j);
      for (int i = 0; i < 292; i++) s[i] = s[i + 1];
      s[292] = f;
    end
    for (int i = 0; i < 293; i++) r[i] = s[i];
    return r;
  endfunction

  function automatic bit is_mark(input int j);
    return (j == 0 || j == 127 || j == 128 || j == 255 || j == 256 || j == 257 || j == 1791);
  endfunction

  task automatic start_pulse(input logic [127:0] k, input logic [127:0] v);
    key_in  = k;
    iv_in   = v;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Full run: start, monitor the message bit, time done, compare final state.
  // With poke set, a start and new key/IV are driven at cycle 50 and must be ignored.
  task automatic run_check(input logic [127:0] k, input logic [127:0] v, input bit poke,
                           input string tag);
    logic [292:0] exp;
    int done_a_c;
    int done_b_c;
    exp = model_init(k, v);
    done_a_c = -1;
    done_b_c = -1;
    start_pulse(k, v);
    check({tag, "_start_busy"}, busy_a, 1);
    check({tag, "_start_done"}, done_a, 0);
    check({tag, "_start_state"}, state_a, 0);
    check({tag, "_start_step"}, step_a, 0);
    for (int c = 0; c <= STEPS + 100; c++) begin
      if (busy_a && is_mark(int'(step_a)))
        check($sformatf("%s_msg%0d", tag, step_a), dut_a.w_msg[0],
              model_msg(k, v, int'(step_a)));
      if (done_b && done_b_c < 0) done_b_c = c;
      if (done_a) begin
        done_a_c = c;
        break;
      end
      if (poke && c == 50) begin
        start_i = 1'b1;
        key_in  = ~k;
        iv_in   = ~v;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
    check({tag, "_latency_p1"}, done_a_c, STEPS);
    check({tag, "_latency_p16"}, done_b_c, STEPS / 16);
    check({tag, "_busy_end"}, busy_a, 0);
    check({tag, "_state_p1"}, state_a, exp);
    check({tag, "_state_p16"}, state_b, exp);
    check({tag, "_step_p1"}, step_a, STEPS - 1);
    check({tag, "_step_p16"}, step_b, STEPS - 16);
  endtask

  initial begin
    logic [127:0] k2, v2, kr, vr;
    logic [292:0] frozen;
    k2 = 128'h000102030405060708090a0b0c0d0e0f;
    v2 = 128'hffeeddccbbaa99887766554433221100;

    // Reset values.
    #12;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_state", state_a, 0);
    check("rst_step", step_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_check('0, '0, 1'b0, "zero");

    // DONE freezes the state and ignores abort.
    frozen = state_a;
    abort_i = 1'b1;
    repeat (3) @(negedge clk);
    abort_i = 1'b0;
    check("done_abort_done", done_a, 1);
    check("done_abort_state", state_a, frozen);

    // Restart from DONE with the pattern key (key[0]=1 for the schedule marks).
    run_check(k2, v2, 1'b0, "pattern");

    // Abort at cycle 100 of RUN, then rerun with the same inputs.
    start_pulse(k2, v2);
    repeat (99) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_state", state_a, 0);
    check("abort_step", step_a, 0);
    run_check(k2, v2, 1'b0, "after_abort");

    // Start and key/IV changes while busy are ignored.
    kr = {$urandom, $urandom, $urandom, $urandom};
    vr = {$urandom, $urandom, $urandom, $urandom};
    run_check(kr, vr, 1'b1, "busy_poke");

    // Asynchronous reset between edges mid-run.
    start_pulse(kr, vr);
    repeat ($urandom_range(200, 400)) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy_a, 0);
    check("arst_done", done_a, 0);
    check("arst_state", state_a, 0);
    check("arst_step", step_a, 0);
    check("arst_state_p16", state_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("arst_idle_busy", busy_a, 0);
    check("arst_idle_done", done_a, 0);

    kr = {$urandom, $urandom, $urandom, $urandom};
    vr = {$urandom, $urandom, $urandom, $urandom};
    run_check(kr, vr, 1'b0, "post_reset");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
